// File: rtl/pio_multi_channel_if.sv
// Avalon-MM slave bus of the PIO block plus its level interrupt.
// Read data is registered (1-cycle latency); writes have no wait states and no backpressure.
interface pio_multi_channel_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );
endinterface

// File: rtl/pio_multi_channel.sv
// Parallel I/O: set/clear output register, synchronised + debounced inputs, edge capture, maskable irq.
// Read data 1 cycle after avs_read, writes act on their own edge; no wait states, no backpressure.
module pio_multi_channel #(
  parameter int                   IN_WIDTH        = 12,
  parameter int                   OUT_WIDTH       = 8,
  parameter int                   SYNC_STAGES     = 2,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  pio_multi_channel_if.slave   avs,
  input  logic [IN_WIDTH-1:0]  in_export,
  output logic [OUT_WIDTH-1:0] out_export
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    A_IN     = 3'd0;
  localparam logic [2:0]    A_OUT    = 3'd1;
  localparam logic [2:0]    A_SET    = 3'd2;
  localparam logic [2:0]    A_CLR    = 3'd3;
  localparam logic [2:0]    A_ECAP   = 3'd4;
  localparam logic [2:0]    A_RISE   = 3'd5;
  localparam logic [2:0]    A_FALL   = 3'd6;
  localparam logic [2:0]    A_MASK   = 3'd7;

  logic [IN_WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [CW-1:0]        cnt_q  [IN_WIDTH];
  logic [CW-1:0]        cnt_d  [IN_WIDTH];
  logic [IN_WIDTH-1:0]  sync_val;
  logic [IN_WIDTH-1:0]  stable_q, stable_d;
  logic [IN_WIDTH-1:0]  rise, fall, w1c;
  logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
  logic [IN_WIDTH-1:0]  rise_en_q, fall_en_q, irq_mask_q;
  logic [IN_WIDTH-1:0]  wdata_in;
  logic [OUT_WIDTH-1:0] data_out_q, wdata_out;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  assign wdata_in     = avs.avs_writedata[IN_WIDTH-1:0];
  assign wdata_out    = avs.avs_writedata[OUT_WIDTH-1:0];
  assign unused_wdata = ^avs.avs_writedata;
  assign sync_val     = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_export;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Any cycle where the synchronised level matches stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < IN_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_val[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = sync_val[i];
        else                     cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Capture uses the next stable value so it lands on the same edge as DATA_IN; a new edge beats a W1C.
  always_comb begin
    rise       = stable_d & ~stable_q;
    fall       = ~stable_d & stable_q;
    w1c        = (avs.avs_write && avs.avs_address == A_ECAP) ? wdata_in : '0;
    edge_cap_d = (edge_cap_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_cap_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_mask_q <= '0;
      data_out_q <= OUT_RESET;
    end else begin
      edge_cap_q <= edge_cap_d;
      if (avs.avs_write) begin
        case (avs.avs_address)
          A_OUT:   data_out_q <= wdata_out;
          A_SET:   data_out_q <= data_out_q | wdata_out;
          A_CLR:   data_out_q <= data_out_q & ~wdata_out;
          A_RISE:  rise_en_q  <= wdata_in;
          A_FALL:  fall_en_q  <= wdata_in;
          A_MASK:  irq_mask_q <= wdata_in;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      A_IN:    rd_mux[IN_WIDTH-1:0]  = stable_q;
      A_OUT:   rd_mux[OUT_WIDTH-1:0] = data_out_q;
      A_ECAP:  rd_mux[IN_WIDTH-1:0]  = edge_cap_q;
      A_RISE:  rd_mux[IN_WIDTH-1:0]  = rise_en_q;
      A_FALL:  rd_mux[IN_WIDTH-1:0]  = fall_en_q;
      A_MASK:  rd_mux[IN_WIDTH-1:0]  = irq_mask_q;
      default: rd_mux = '0;
    endcase
  end

  // Mux samples pre-write state, so a combined read+write returns the old value.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)     avs.avs_readdata <= '0;
    else if (avs.avs_read)  avs.avs_readdata <= rd_mux;
  end

  assign avs.irq    = |(edge_cap_q & irq_mask_q);
  assign out_export = data_out_q;

endmodule

// File: tb/tb_pio_multi_channel.sv
// Scoreboard bench for pio_multi_channel: directed scenarios followed by random bus/input traffic.
module tb_pio_multi_channel;
  localparam int IW = 12;
  localparam int OW = 8;
  localparam int SS = 2;
  localparam int DC = 4;

  logic          clk_clk       = 1'b0;
  logic          reset_reset_n = 1'b1;
  logic [IW-1:0] in_export     = '0;
  logic [OW-1:0] out_export;

  pio_multi_channel_if bus();

  pio_multi_channel #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .OUT_RESET(8'h00)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs           (bus),
    .in_export     (in_export),
    .out_export    (out_export)
  );

  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pin level is accepted once the last DC synchronised samples all agree.
  typedef struct { logic [2:0] a; logic [31:0] v; } rd_exp_t;
  rd_exp_t       exp_q[$];
  bit            rd_pend = 1'b0;
  bit [IW-1:0]   m_hist [SS+DC];
  bit [IW-1:0]   m_stable = '0, m_ecap = '0, m_ren = '0, m_fen = '0, m_mask = '0;
  bit [OW-1:0]   m_out = '0;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_stable);
      3'd1:    return 32'(m_out);
      3'd4:    return 32'(m_ecap);
      3'd5:    return 32'(m_ren);
      3'd6:    return 32'(m_fen);
      3'd7:    return 32'(m_mask);
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge reset_reset_n) begin
    for (int j = 0; j < SS+DC; j++) m_hist[j] = '0;
    m_stable = '0; m_ecap = '0; m_ren = '0; m_fen = '0; m_mask = '0;
    m_out = '0; rd_pend = 1'b0;
    exp_q.delete();
  end

  always @(posedge clk_clk) begin : model
    bit [IW-1:0] all1, all0, nxt, rise, fall, w1c, wd;
    rd_exp_t     e;
    if (reset_reset_n) begin
      rd_pend = bus.avs_read;
      if (bus.avs_read) begin
        e.a = bus.avs_address;
        e.v = m_read(bus.avs_address);
        exp_q.push_back(e);
      end
      for (int j = SS+DC-1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = in_export;
      all1 = '1;
      all0 = '1;
      for (int j = SS; j < SS+DC; j++) begin
        all1 &= m_hist[j];
        all0 &= ~m_hist[j];
      end
      nxt  = (m_stable | all1) & ~all0;
      rise = nxt & ~m_stable;
      fall = ~nxt & m_stable;
      wd   = bus.avs_writedata[IW-1:0];
      w1c  = (bus.avs_write && bus.avs_address == 3'd4) ? wd : '0;
      m_ecap   = (m_ecap & ~w1c) | (rise & m_ren) | (fall & m_fen);
      m_stable = nxt;
      if (bus.avs_write) begin
        case (bus.avs_address)
          3'd1: m_out = bus.avs_writedata[OW-1:0];
          3'd2: m_out = m_out | bus.avs_writedata[OW-1:0];
          3'd3: m_out = m_out & ~bus.avs_writedata[OW-1:0];
          3'd5: m_ren  = wd;
          3'd6: m_fen  = wd;
          3'd7: m_mask = wd;
          default: ;
        endcase
      end
    end
  end

  // Monitor: pins every cycle, read data one cycle after each accepted read.
  always @(negedge clk_clk) begin : monitor
    rd_exp_t e;
    chk("out_export", 32'(out_export), 32'(m_out));
    chk("irq", 32'(bus.irq), 32'(|(m_ecap & m_mask)));
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_queue: got read data with no expected entry at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("readdata_a%0d", e.a), bus.avs_readdata, e.v);
      end
    end
  end

  task automatic drive(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d);
    bus.avs_read      = rd;
    bus.avs_write     = wr;
    bus.avs_address   = a;
    bus.avs_writedata = d;
    @(negedge clk_clk);
  endtask

  initial begin
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_address = '0; bus.avs_writedata = '0;
    #1 reset_reset_n = 1'b0;
    #2;
    chk("rst_out", 32'(out_export), 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    chk("rst_rdata", bus.avs_readdata, 32'h0);
    repeat (2) @(negedge clk_clk);
    #2 reset_reset_n = 1'b1;
    @(negedge clk_clk);

    for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, 3'(a), 32'h0);
    drive(1'b0, 1'b0, 3'd0, 32'h0);

    drive(1'b0, 1'b1, 3'd1, 32'hA5);
    chk("out_a5", 32'(out_export), 32'hA5);
    drive(1'b0, 1'b1, 3'd2, 32'h0F);
    chk("out_af", 32'(out_export), 32'hAF);
    drive(1'b0, 1'b1, 3'd3, 32'h81);
    chk("out_2e", 32'(out_export), 32'h2E);
    drive(1'b1, 1'b0, 3'd1, 32'h0);
    chk("rd_data_out", bus.avs_readdata, 32'h2E);

    drive(1'b0, 1'b1, 3'd5, 32'h008);
    drive(1'b0, 1'b1, 3'd7, 32'h008);
    in_export = 12'h008;
    repeat (5) drive(1'b1, 1'b0, 3'd0, 32'h0);
    chk("irq_pre_edge6", 32'(bus.irq), 32'h0);
    drive(1'b1, 1'b0, 3'd4, 32'h0);
    chk("irq_edge6", 32'(bus.irq), 32'h1);
    drive(1'b1, 1'b0, 3'd4, 32'h0);
    chk("ecap_bit3", bus.avs_readdata, 32'h008);
    drive(1'b0, 1'b1, 3'd4, 32'h008);
    chk("irq_w1c", 32'(bus.irq), 32'h0);

    for (int k = 0; k < 4; k++) begin
      in_export[0] = (k % 2 == 0);
      drive(1'b1, 1'b0, 3'd0, 32'h0);
    end
    in_export[0] = 1'b1;
    repeat (6) drive(1'b1, 1'b0, 3'd0, 32'h0);
    chk("db_edge5", bus.avs_readdata & 32'h1, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 32'h0);
    chk("db_edge6", bus.avs_readdata & 32'h1, 32'h1);

    drive(1'b0, 1'b1, 3'd6, 32'h800);
    in_export[11] = 1'b1;
    repeat (8) drive(1'b0, 1'b0, 3'd0, 32'h0);
    in_export[11] = 1'b0;
    repeat (5) drive(1'b0, 1'b0, 3'd0, 32'h0);
    drive(1'b0, 1'b1, 3'd4, 32'h800);
    drive(1'b1, 1'b0, 3'd4, 32'h0);
    chk("ecap_set_wins", bus.avs_readdata, 32'h800);

    chk("out_pre_rst", 32'(out_export), 32'h2E);
    in_export[5] = 1'b1;
    repeat (4) drive(1'b0, 1'b0, 3'd0, 32'h0);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("async_out", 32'(out_export), 32'h0);
    chk("async_rdata", bus.avs_readdata, 32'h0);
    chk("async_irq", 32'(bus.irq), 32'h0);
    @(negedge clk_clk);
    #2 reset_reset_n = 1'b1;
    repeat (6) drive(1'b1, 1'b0, 3'd0, 32'h0);
    chk("post_rst_edge5", bus.avs_readdata, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 32'h0);
    chk("post_rst_edge6", bus.avs_readdata, 32'h029);

    for (int c = 0; c < 1500; c++) begin
      int op, bit_idx;
      if ($urandom_range(0, 5) == 0) begin
        bit_idx = $urandom_range(0, IW-1);
        in_export[bit_idx] = ~in_export[bit_idx];
      end
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: drive(1'b1, 1'b0, 3'($urandom_range(0, 7)), 32'h0);
        3, 4, 5: drive(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom);
        6:       drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom);
        default: drive(1'b0, 1'b0, 3'd0, 32'h0);
      endcase
    end
    repeat (3) drive(1'b0, 1'b0, 3'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
